// File: rtl/reg_status_file.sv
// Architectural register file with rename status: per-register value, dirty bit and producing ROB tag.
// Lookups are combinational. State, busy_count and err_sticky update one cycle after the inputs.
// rdy_in=0 freezes all state; lookups keep resolving from the held state.
module reg_status_file #(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int RID_W   = 5,
  parameter int ROB_BIT = 4,
  parameter int NUM_RD  = 2
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      commit_valid,
  input  logic [RID_W-1:0]          commit_reg_id,
  input  logic [XLEN-1:0]           commit_data,
  input  logic [ROB_BIT-1:0]        commit_rob_entry,
  input  logic                      issue_valid,
  input  logic [RID_W-1:0]          issue_reg_id,
  input  logic [ROB_BIT-1:0]        issue_rob_entry,
  input  logic [NUM_RD*RID_W-1:0]   rd_id,
  output logic [NUM_RD*XLEN-1:0]    rd_val,
  output logic [NUM_RD-1:0]         rd_has_dep,
  output logic [NUM_RD*ROB_BIT-1:0] rd_dep,
  output logic [NUM_RD*ROB_BIT-1:0] rob_q_entry,
  input  logic [NUM_RD-1:0]         rob_q_ready,
  input  logic [NUM_RD*XLEN-1:0]    rob_q_value,
  output logic [RID_W:0]            busy_count,
  output logic                      err_sticky
);

  logic [XLEN-1:0]    regs    [NREGS];
  logic [ROB_BIT-1:0] tag     [NREGS];
  logic [ROB_BIT-1:0] tag_nxt [NREGS];
  logic [NREGS-1:0]   dirty;
  logic [NREGS-1:0]   dirty_nxt;
  logic [RID_W:0]     busy_nxt;

  // Writes to x0 are discarded, so both paths qualify on a non-zero index.
  logic commit_hit;
  logic issue_hit;
  logic commit_clr;
  logic err_set;

  assign commit_hit = commit_valid && (commit_reg_id != '0);
  assign issue_hit  = issue_valid && (issue_reg_id != '0);
  // Only the youngest producer may release the rename; a same-cycle issue re-renames instead.
  assign commit_clr = commit_hit && (tag[commit_reg_id] == commit_rob_entry) &&
                      !(issue_valid && (issue_reg_id == commit_reg_id));
  assign err_set    = (commit_hit && !flush_in && !dirty[commit_reg_id]) ||
                      (issue_valid && (issue_reg_id == '0));

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [RID_W-1:0] idx;
    assign idx = rd_id[k*RID_W +: RID_W];

    // Per-port operand resolution; the first matching source wins, newest information first.
    always_comb begin
      rd_val[k*XLEN +: XLEN]          = '0;
      rd_has_dep[k]                   = 1'b0;
      rd_dep[k*ROB_BIT +: ROB_BIT]    = '0;
      rob_q_entry[k*ROB_BIT +: ROB_BIT] = tag[idx];
      if (idx == '0) begin
        rd_val[k*XLEN +: XLEN] = '0;
      end else if (issue_valid && (issue_reg_id == idx)) begin
        rd_has_dep[k]                = 1'b1;
        rd_dep[k*ROB_BIT +: ROB_BIT] = issue_rob_entry;
      end else if (dirty[idx] && commit_valid && (commit_reg_id == idx) &&
                   (commit_rob_entry == tag[idx])) begin
        rd_val[k*XLEN +: XLEN] = commit_data;
      end else if (dirty[idx] && rob_q_ready[k]) begin
        rd_val[k*XLEN +: XLEN] = rob_q_value[k*XLEN +: XLEN];
      end else if (dirty[idx]) begin
        rd_has_dep[k]                = 1'b1;
        rd_dep[k*ROB_BIT +: ROB_BIT] = tag[idx];
      end else begin
        rd_val[k*XLEN +: XLEN] = regs[idx];
      end
    end
  end

  // Next rename state: commit release, then flush wipe or issue rename, plus its popcount.
  always_comb begin
    dirty_nxt = dirty;
    for (int i = 0; i < NREGS; i++) tag_nxt[i] = tag[i];
    if (commit_clr) begin
      dirty_nxt[commit_reg_id] = 1'b0;
      tag_nxt[commit_reg_id]   = '0;
    end
    if (flush_in) begin
      dirty_nxt = '0;
      for (int i = 0; i < NREGS; i++) tag_nxt[i] = '0;
    end else if (issue_hit) begin
      dirty_nxt[issue_reg_id] = 1'b1;
      tag_nxt[issue_reg_id]   = issue_rob_entry;
    end
    busy_nxt = '0;
    for (int i = 0; i < NREGS; i++) busy_nxt = busy_nxt + (RID_W+1)'(dirty_nxt[i]);
  end

  // Architectural values: committed data lands even during a flush.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (rdy_in && commit_hit) begin
      regs[commit_reg_id] <= commit_data;
    end
  end

  // Rename state, busy counter and sticky protocol error.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      dirty      <= '0;
      busy_count <= '0;
      err_sticky <= 1'b0;
      for (int i = 0; i < NREGS; i++) tag[i] <= '0;
    end else if (rdy_in) begin
      dirty      <= dirty_nxt;
      busy_count <= busy_nxt;
      if (err_set) err_sticky <= 1'b1;
      for (int i = 0; i < NREGS; i++) tag[i] <= tag_nxt[i];
    end
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: directed scenarios followed by random traffic.
// Expected lookups/status are computed from an array model when inputs are driven.
// A negedge monitor pops and compares against the DUT outputs.
module tb_reg_status_file;
  localparam int XLEN = 32, NREGS = 32, RID_W = 5, ROB_BIT = 4, NUM_RD = 2;

  logic                      clk_in = 1'b0;
  logic                      rst_in, rdy_in, flush_in;
  logic                      commit_valid, issue_valid;
  logic [RID_W-1:0]          commit_reg_id, issue_reg_id;
  logic [XLEN-1:0]           commit_data;
  logic [ROB_BIT-1:0]        commit_rob_entry, issue_rob_entry;
  logic [NUM_RD*RID_W-1:0]   rd_id;
  logic [NUM_RD*XLEN-1:0]    rd_val;
  logic [NUM_RD-1:0]         rd_has_dep;
  logic [NUM_RD*ROB_BIT-1:0] rd_dep;
  logic [NUM_RD*ROB_BIT-1:0] rob_q_entry;
  logic [NUM_RD-1:0]         rob_q_ready;
  logic [NUM_RD*XLEN-1:0]    rob_q_value;
  logic [RID_W:0]            busy_count;
  logic                      err_sticky;

  reg_status_file #(.XLEN(XLEN), .NREGS(NREGS), .RID_W(RID_W), .ROB_BIT(ROB_BIT), .NUM_RD(NUM_RD)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_valid(commit_valid), .commit_reg_id(commit_reg_id), .commit_data(commit_data),
    .commit_rob_entry(commit_rob_entry), .issue_valid(issue_valid), .issue_reg_id(issue_reg_id),
    .issue_rob_entry(issue_rob_entry), .rd_id(rd_id), .rd_val(rd_val), .rd_has_dep(rd_has_dep),
    .rd_dep(rd_dep), .rob_q_entry(rob_q_entry), .rob_q_ready(rob_q_ready),
    .rob_q_value(rob_q_value), .busy_count(busy_count), .err_sticky(err_sticky)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [NUM_RD*XLEN-1:0]    val;
    logic [NUM_RD-1:0]         has_dep;
    logic [NUM_RD*ROB_BIT-1:0] dep;
    logic [NUM_RD*ROB_BIT-1:0] qe;
    logic [RID_W:0]            busy;
    logic                      err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain arrays of architectural state.
  logic [XLEN-1:0]    m_regs  [NREGS];
  logic               m_dirty [NREGS];
  logic [ROB_BIT-1:0] m_tag   [NREGS];
  logic               m_err;

  function automatic void model_clear();
    for (int i = 0; i < NREGS; i++) begin
      m_regs[i] = '0; m_dirty[i] = 1'b0; m_tag[i] = '0;
    end
    m_err = 1'b0;
  endfunction

  function automatic exp_t model_lookup();
    exp_t e;
    int   r;
    e.val = '0; e.has_dep = '0; e.dep = '0; e.qe = '0; e.busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      r = int'(rd_id[k*RID_W +: RID_W]);
      e.qe[k*ROB_BIT +: ROB_BIT] = m_tag[r];
      if (r == 0) begin
      end else if (issue_valid && int'(issue_reg_id) == r) begin
        e.has_dep[k] = 1'b1; e.dep[k*ROB_BIT +: ROB_BIT] = issue_rob_entry;
      end else if (m_dirty[r] && commit_valid && int'(commit_reg_id) == r && commit_rob_entry == m_tag[r]) begin
        e.val[k*XLEN +: XLEN] = commit_data;
      end else if (m_dirty[r] && rob_q_ready[k]) begin
        e.val[k*XLEN +: XLEN] = rob_q_value[k*XLEN +: XLEN];
      end else if (m_dirty[r]) begin
        e.has_dep[k] = 1'b1; e.dep[k*ROB_BIT +: ROB_BIT] = m_tag[r];
      end else begin
        e.val[k*XLEN +: XLEN] = m_regs[r];
      end
    end
    for (int i = 0; i < NREGS; i++) e.busy = e.busy + (RID_W+1)'(m_dirty[i]);
    e.err = m_err;
    return e;
  endfunction

  // Applied at a clock edge with reset released and rdy_in high.
  function automatic void model_update();
    int c = int'(commit_reg_id);
    int s = int'(issue_reg_id);
    if (commit_valid && c != 0) begin
      if (!flush_in && !m_dirty[c]) m_err = 1'b1;
      m_regs[c] = commit_data;
      if (m_tag[c] == commit_rob_entry && !(issue_valid && s == c)) begin
        m_dirty[c] = 1'b0; m_tag[c] = '0;
      end
    end
    if (issue_valid && s == 0) m_err = 1'b1;
    if (flush_in) begin
      for (int i = 0; i < NREGS; i++) begin m_dirty[i] = 1'b0; m_tag[i] = '0; end
    end else if (issue_valid && s != 0) begin
      m_dirty[s] = 1'b1; m_tag[s] = issue_rob_entry;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: the combinational outputs are presented every cycle; compare mid-cycle.
  always @(negedge clk_in) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("rd_val", 64'(rd_val), 64'(e.val));
      chk("rd_has_dep", 64'(rd_has_dep), 64'(e.has_dep));
      chk("rd_dep", 64'(rd_dep), 64'(e.dep));
      chk("rob_q_entry", 64'(rob_q_entry), 64'(e.qe));
      chk("busy_count", 64'(busy_count), 64'(e.busy));
      chk("err_sticky", 64'(err_sticky), 64'(e.err));
    end
  end

  task automatic idle();
    rdy_in = 1'b1; flush_in = 1'b0;
    commit_valid = 1'b0; commit_reg_id = '0; commit_data = '0; commit_rob_entry = '0;
    issue_valid = 1'b0; issue_reg_id = '0; issue_rob_entry = '0;
    rob_q_ready = '0; rob_q_value = '0;
  endtask

  task automatic set_rd(input int a, input int b);
    rd_id = {RID_W'(b), RID_W'(a)};
  endtask

  task automatic issue(input int r, input int t);
    issue_valid = 1'b1; issue_reg_id = RID_W'(r); issue_rob_entry = ROB_BIT'(t);
  endtask

  task automatic commit(input int r, input int t, input logic [XLEN-1:0] d);
    commit_valid = 1'b1; commit_reg_id = RID_W'(r); commit_rob_entry = ROB_BIT'(t); commit_data = d;
  endtask

  // Inputs are settled here: record the expectation, then let the clock edge advance state.
  task automatic step();
    sb.push_back(model_lookup());
    @(posedge clk_in);
    if (rst_in && rdy_in) model_update();
    #1;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0;
    idle();
    set_rd(5, 5);
    model_clear();
    @(posedge clk_in); #1;

    // Reset state
    set_rd(5, 5); step();
    rst_in = 1'b1;
    set_rd(5, 5); step();

    // Issue/lookup same cycle, then ROB forwarding
    issue(5, 3); set_rd(5, 5); step();
    set_rd(5, 5); step();
    rob_q_ready = 2'b11; rob_q_value = {32'hAB, 32'hAB}; set_rd(5, 5); step();
    commit(5, 3, 32'hAB); set_rd(5, 0); step();

    // Commit bypass and regs read-back
    issue(7, 2); set_rd(7, 0); step();
    commit(7, 2, 32'h1234); set_rd(7, 7); step();
    set_rd(7, 7); step();

    // Stale commit vs younger rename; issue beats commit-clear
    issue(7, 1); set_rd(7, 7); step();
    issue(7, 4); set_rd(7, 7); step();
    commit(7, 1, 32'd9); set_rd(7, 7); step();
    set_rd(7, 0); step();
    commit(7, 4, 32'd11); issue(7, 6); set_rd(7, 7); step();
    set_rd(7, 7); step();
    commit(7, 6, 32'd12); set_rd(7, 7); step();

    // Flush with commit and dropped issue
    issue(3, 5); set_rd(3, 4); step();
    issue(4, 6); set_rd(3, 4); step();
    flush_in = 1'b1; commit(3, 5, 32'd7); issue(9, 1); set_rd(3, 9); step();
    set_rd(3, 9); step();

    // Protocol error, rdy_in hold, async reset
    commit(10, 0, 32'h55); set_rd(10, 0); step();
    set_rd(10, 11); step();
    rdy_in = 1'b0; issue(11, 2); set_rd(11, 11); step();
    set_rd(11, 10); step();
    issue(12, 3); set_rd(12, 10); step();
    rst_in = 1'b0; model_clear(); set_rd(12, 10); step();
    rst_in = 1'b1; set_rd(12, 10); step();

    // Randomized traffic over a small register window to force collisions
    for (int n = 0; n < 800; n++) begin
      int r;
      if ($urandom_range(99) < 8) rdy_in = 1'b0;
      if ($urandom_range(99) < 4) flush_in = 1'b1;
      if ($urandom_range(99) < 50) begin
        r = ($urandom_range(99) < 2) ? 0 : int'($urandom_range(7, 1));
        issue(r, int'($urandom_range(15)));
      end
      if ($urandom_range(99) < 50) begin
        r = int'($urandom_range(7));
        commit(r, ($urandom_range(99) < 70) ? int'(m_tag[r]) : int'($urandom_range(15)), $urandom());
      end
      rob_q_ready = NUM_RD'($urandom_range(3));
      rob_q_value = {$urandom(), $urandom()};
      set_rd(int'($urandom_range(7)), int'($urandom_range(7)));
      if ($urandom_range(999) < 5) begin
        rst_in = 1'b0; model_clear();
      end
      step();
      rst_in = 1'b1;
    end

    @(negedge clk_in); #1;
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
